mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: start  in  1  request to begin a multiply; accepted only when busy=0.
REQ-004 SHALL have: op_a  in  64  multiplicand, fed from the register-file read port A (DRA).
REQ-005 SHALL have: op_b  in  64  multiplier, fed from the register-file read port B (DRB).
REQ-006 SHALL have: dest  in  5  destination register index.
REQ-007 SHALL have: busy  out  1  high from the accept edge until returning to IDLE.
REQ-008 SHALL have: done  out  1  one-cycle pulse marking the result cycle.
REQ-009 SHALL have: wr_data  out  64  product, driving the register-file write data.
REQ-010 SHALL have: wr_reg  out  5  destination index, driving the register-file write select.
REQ-011 SHALL have: wr_en  out  1  register-file write enable, one-cycle pulse.
REQ-012 Parameters: WIDTH, default 64, operand/result width; ITER, default 64, iteration count (= WIDTH).

Function
REQ-013 Result SHALL be the low WIDTH bits of op_a*op_b; overflow bits are discarded, so signed and unsigned operands give the same result.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: on a rising edge with start=1, capture op_a, op_b and dest, clear the accumulator and counter, and go to RUN.
REQ-016 IDLE with start=0: no state change.
REQ-017 RUN, every edge: if multiplier bit0=1, acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-018 RUN SHALL go to DONE on the edge that completes iteration ITER; there is no early termination.
REQ-019 DONE: done=1 for exactly one cycle; wr_data = acc; wr_reg = captured dest; then return to IDLE on the next edge.
REQ-020 In the DONE cycle, wr_en SHALL equal 1 unless the captured dest = 31; register 31 is hardwired zero, so wr_en stays 0 and done still pulses.
REQ-021 Latency: with the accept edge as E0, done/wr_en SHALL be high in the cycle after edge E64, and busy returns to 0 after E65.
REQ-022 start while busy=1, including during DONE, SHALL be ignored with no queuing, and SHALL not perturb captured operands.
REQ-023 op_a, op_b and dest SHALL be sampled only on the accept edge; later changes have no effect.
REQ-024 Outside the DONE cycle: wr_en=0, done=0, wr_data=0, wr_reg=0.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear acc, counter and captured operands, with busy=done=wr_en=0, wr_data=0, wr_reg=0.
REQ-026 Reset mid-RUN or in DONE SHALL abort the operation with no write issued; start is first honoured on the first rising edge after rst_n is released.

Structure
REQ-027 A shared package mul_pkg SHALL hold the state enum (IDLE/RUN/DONE), WIDTH=64, ITER=64 and REG_ZERO=31.
REQ-028 The counter SHALL be $clog2(ITER)+1 bits wide.
REQ-029 One combinational sub-module, shift_add_step, SHALL compute the next acc, multiplicand and multiplier from the current ones.
REQ-030 mul_unit SHALL hold all registers and the FSM.

Verification
REQ-031 op_a=3, op_b=5, dest=2, start at E0 -> wr_en=1, wr_data=15, wr_reg=2 in the cycle after E64, and busy=0 after E65.
REQ-032 op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> wr_data=0xFFFF_FFFF_FFFF_FFFE (wrapped; the same as -1*2).
REQ-033 dest=31, op_a=7, op_b=9 -> done pulses after E64 and wr_en stays 0 throughout.
REQ-034 Accept 4*6 with dest=1, then pulse start at E10 with op_a=100, op_b=100 -> exactly one write, wr_data=24, no second done.
REQ-035 Accept 11*13, then drop rst_n at E30 -> outputs 0 immediately; after release, no wr_en ever appears for the aborted op, and a new 2*2 yields 4 at the nominal latency.
REQ-036 op_a=0, op_b=0xDEAD -> wr_data=0 with wr_en=1 at the full 65-cycle latency (no early exit).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned ITER     = 64;
  localparam logic [4:0]  REG_ZERO = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/shift_add_step.sv
// One combinational iteration of the shift-add multiply: conditional add, then shift both operands.
module shift_add_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  always_comb begin
    // Carry out of the add is dropped: result is the product mod 2^WIDTH.
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/mul_unit.sv
// Multi-cycle multiplier feeding a register-file write port; fixed ITER-cycle latency.
module mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = mul_pkg::WIDTH,
  parameter int unsigned ITER  = mul_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wr_data,
  output logic [4:0]       wr_reg,
  output logic             wr_en
);

  localparam int unsigned CntW = $clog2(ITER) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [4:0]       dest_q, dest_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_step, mcand_step, mplier_step;

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplier_i(mplier_q),
    .acc_o   (acc_step),
    .mcand_o (mcand_step),
    .mplier_o(mplier_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          dest_d   = dest;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + CntW'(1);
        // No early exit: always run all ITER iterations for fixed latency.
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dest_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    wr_data = done ? acc_q : '0;
    wr_reg  = done ? dest_q : '0;
    // Register 31 is hardwired zero, so suppress the write but keep the done pulse.
    wr_en   = done && (dest_q != REG_ZERO);
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit with hand-computed products and cycle-exact latency checks.
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [4:0]  dest;
  logic        busy;
  logic        done;
  logic [63:0] wr_data;
  logic [4:0]  wr_reg;
  logic        wr_en;

  int checks;
  int errors;
  int wr_cnt;
  int done_cnt;
  int base_wr;
  int base_done;

  mul_unit u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .dest   (dest),
    .busy   (busy),
    .done   (done),
    .wr_data(wr_data),
    .wr_reg (wr_reg),
    .wr_en  (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each pulse is high across exactly one negedge, so this counts pulses.
  always @(negedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (done)  done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op before the edge, hold start for one edge (E0), then scramble the inputs.
  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    dest  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 64'h5A5A_5A5A_5A5A_5A5A;
    op_b  = 64'hFFFF_0000_FFFF_0000;
    dest  = 5'd17;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    dest  = '0;

    #12;
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_wr_en",   64'(wr_en),   64'd0);
    check("rst_wr_data", wr_data,      64'd0);
    check("rst_wr_reg",  64'(wr_reg),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3*5 -> r2, exact latency
    accept(64'd3, 64'd5, 5'd2);
    check("t1_busy_e0", 64'(busy), 64'd1);
    wait_edges(63);
    check("t1_done_e63",  64'(done),  64'd0);
    check("t1_wr_en_e63", 64'(wr_en), 64'd0);
    wait_edges(1);
    check("t1_done",    64'(done),   64'd1);
    check("t1_wr_en",   64'(wr_en),  64'd1);
    check("t1_wr_data", wr_data,     64'd15);
    check("t1_wr_reg",  64'(wr_reg), 64'd2);
    check("t1_busy",    64'(busy),   64'd1);
    wait_edges(1);
    check("t1_busy_e65",  64'(busy),   64'd0);
    check("t1_done_e65",  64'(done),   64'd0);
    check("t1_data_e65",  wr_data,     64'd0);
    check("t1_reg_e65",   64'(wr_reg), 64'd0);

    // all-ones * 2 wraps
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3);
    wait_edges(64);
    check("t2_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_wr_en",   64'(wr_en), 64'd1);
    wait_edges(1);

    // -3 * 5 = -15 mod 2^64
    accept(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd9);
    wait_edges(64);
    check("t3_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFF1);
    check("t3_wr_reg",  64'(wr_reg), 64'd9);
    wait_edges(1);

    // dest 31: done pulses, no write
    base_wr = wr_cnt;
    accept(64'd7, 64'd9, 5'd31);
    wait_edges(64);
    check("t4_done",    64'(done),   64'd1);
    check("t4_wr_en",   64'(wr_en),  64'd0);
    check("t4_wr_data", wr_data,     64'd63);
    check("t4_wr_reg",  64'(wr_reg), 64'd31);
    wait_edges(1);
    check("t4_no_write", 64'(wr_cnt - base_wr), 64'd0);

    // start while busy (at E10 and during DONE) is ignored
    base_wr   = wr_cnt;
    base_done = done_cnt;
    accept(64'd4, 64'd6, 5'd1);
    wait_edges(9);
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd100;
    op_b  = 64'd100;
    dest  = 5'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_edges(54);
    check("t5_wr_data", wr_data,     64'd24);
    check("t5_wr_reg",  64'(wr_reg), 64'd1);
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd100;
    op_b  = 64'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5_busy_after_done", 64'(busy), 64'd0);
    wait_edges(70);
    check("t5_one_write", 64'(wr_cnt - base_wr),     64'd1);
    check("t5_one_done",  64'(done_cnt - base_done), 64'd1);

    // reset mid-run aborts the op
    accept(64'd11, 64'd13, 5'd4);
    wait_edges(29);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",    64'(busy),  64'd0);
    check("t6_rst_wr_data", wr_data,    64'd0);
    check("t6_rst_wr_en",   64'(wr_en), 64'd0);
    base_wr = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(80);
    check("t6_no_write", 64'(wr_cnt - base_wr), 64'd0);
    accept(64'd2, 64'd2, 5'd5);
    wait_edges(63);
    check("t6_done_e63", 64'(done), 64'd0);
    wait_edges(1);
    check("t6_wr_en",   64'(wr_en), 64'd1);
    check("t6_wr_data", wr_data,    64'd4);
    wait_edges(1);

    // zero multiplicand still takes the full latency
    accept(64'd0, 64'hDEAD, 5'd6);
    wait_edges(63);
    check("t7_done_e63", 64'(done), 64'd0);
    check("t7_busy_e63", 64'(busy), 64'd1);
    wait_edges(1);
    check("t7_wr_en",   64'(wr_en),  64'd1);
    check("t7_wr_data", wr_data,     64'd0);
    check("t7_wr_reg",  64'(wr_reg), 64'd6);
    wait_edges(1);
    check("t7_busy_e65", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
